// File: rtl/counter_pkg.sv
// Shared mode encoding and default sizing for the mode_counter block.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_t;

    localparam int unsigned DEF_WIDTH = 5;
    localparam int unsigned DEF_NCH   = 4;

endpackage

// File: rtl/mode_counter_if.sv
// Control/status bundle for mode_counter: shared mode/limit plus per-channel vectors.
interface mode_counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH
) ();

    mode_t                      mode;
    logic [WIDTH-1:0]           limit;
    logic [NCH-1:0][WIDTH-1:0]  data;
    logic [NCH-1:0]             load;
    logic [NCH-1:0]             enable;
    logic [NCH-1:0]             up;
    logic [NCH-1:0]             clr;
    logic [NCH-1:0][WIDTH-1:0]  count;
    logic [NCH-1:0]             tc;
    logic [NCH-1:0]             ovf;

    modport master (
        output mode, limit, data, load, enable, up, clr,
        input  count, tc, ovf
    );

    modport slave (
        input  mode, limit, data, load, enable, up, clr,
        output count, tc, ovf
    );

endinterface

// File: rtl/count_chan.sv
// One counter channel: load/enable/hold with wrap or saturate at 0..limit,
// terminal-count pulse and sticky overflow flag.
module count_chan
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    // Next state; a count left above a lowered limit is treated as at the boundary.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = (data > limit) ? limit : data;
        end else if (enable) begin
            if (up) begin
                if (count < limit) begin
                    count_nxt = count + WIDTH'(1);
                end else begin
                    count_nxt = (mode == MODE_WRAP) ? '0 : limit;
                    tc_nxt    = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_nxt = count - WIDTH'(1);
                end else begin
                    count_nxt = (mode == MODE_WRAP) ? limit : '0;
                    tc_nxt    = 1'b1;
                end
            end
        end
        // Set wins over clear so a boundary event is never lost.
        ovf_nxt = tc_nxt | (ovf & ~clr);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// NCH independent up/down counters sharing a wrap/saturate mode and an upper limit.
module mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH
) (
    input  logic           clk,
    input  logic           rst_,
    mode_counter_if.slave  bus
);

    logic [NCH-1:0][WIDTH-1:0] count_w;
    logic [NCH-1:0]            tc_w;
    logic [NCH-1:0]            ovf_w;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        count_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst_   (rst_),
            .mode   (bus.mode),
            .limit  (bus.limit),
            .data   (bus.data[i]),
            .load   (bus.load[i]),
            .enable (bus.enable[i]),
            .up     (bus.up[i]),
            .clr    (bus.clr[i]),
            .count  (count_w[i]),
            .tc     (tc_w[i]),
            .ovf    (ovf_w[i])
        );
    end

    assign bus.count = count_w;
    assign bus.tc    = tc_w;
    assign bus.ovf   = ovf_w;

endmodule
